// File: rtl/sobel_window_conv.sv
// Sobel |Gx|+|Gy| edge detector over a 3x3 window, 3-cycle pipeline with eol/eof tracking.
// Optional binarisation of the output is enabled by defining SOBEL_THRESH_EN.
module sobel_window_conv #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          MAG_SHIFT = 0,
  parameter logic [7:0]  THRESH    = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       in_valid,
  input  logic [7:0] t_a,
  input  logic [7:0] t_b,
  input  logic [7:0] t_c,
  input  logic [7:0] m_a,
  input  logic [7:0] m_b,
  input  logic [7:0] m_c,
  input  logic [7:0] b_a,
  input  logic [7:0] b_b,
  input  logic [7:0] b_c,
  output logic       win_req,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       out_eol,
  output logic       out_eof
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Handshake: there is no ready; every cycle with in_valid=1 is an accepted
  // window, and win_req (in_valid delayed one cycle) pops the row buffers once.
  logic [CW-1:0] col_cnt, col_eff, col_nxt;
  logic [RW-1:0] row_cnt, row_eff, row_nxt;
  logic          eol_w, eof_w;

  logic [7:0]  s0_ta, s0_tb, s0_tc, s0_ma, s0_mc, s0_ba, s0_bb, s0_bc;
  logic        s0_valid, s0_eol, s0_eof;
  logic signed [10:0] s1_gx, s1_gy;
  logic        s1_valid, s1_eol, s1_eof;
  logic [10:0] s2_mag;
  logic        s2_valid, s2_eol, s2_eof;

  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] abs_x, abs_y, shifted;
  logic [7:0]  sat, pix_final;

  // frame_start re-bases the window seen in the same cycle to col 0, row 0.
  always_comb begin
    col_eff = frame_start ? '0 : col_cnt;
    row_eff = frame_start ? '0 : row_cnt;
    eol_w   = (col_eff == CW'(IMG_W - 1));
    eof_w   = eol_w && (row_eff == RW'(IMG_H - 1));
    col_nxt = col_eff;
    row_nxt = row_eff;
    if (in_valid) begin
      col_nxt = eol_w ? '0 : col_eff + CW'(1);
      if (eol_w) row_nxt = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
    end
  end

  always_comb begin
    gx_pos  = 11'(s0_tc) + {2'b00, s0_mc, 1'b0} + 11'(s0_bc);
    gx_neg  = 11'(s0_ta) + {2'b00, s0_ma, 1'b0} + 11'(s0_ba);
    gy_pos  = 11'(s0_ba) + {2'b00, s0_bb, 1'b0} + 11'(s0_bc);
    gy_neg  = 11'(s0_ta) + {2'b00, s0_tb, 1'b0} + 11'(s0_tc);
    abs_x   = s1_gx[10] ? (~s1_gx + 11'd1) : s1_gx;
    abs_y   = s1_gy[10] ? (~s1_gy + 11'd1) : s1_gy;
    shifted = s2_mag >> MAG_SHIFT;
    sat     = (shifted > 11'd255) ? 8'hFF : shifted[7:0];
`ifdef SOBEL_THRESH_EN
    pix_final = (sat >= THRESH) ? 8'hFF : 8'h00;
`else
    pix_final = sat;
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  // Control path: valid bits, flags, counters and outputs are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_req   <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      s0_valid  <= 1'b0;
      s0_eol    <= 1'b0;
      s0_eof    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_eol    <= 1'b0;
      s1_eof    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_eol    <= 1'b0;
      s2_eof    <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= 8'd0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      win_req   <= in_valid;
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
      s0_valid  <= in_valid;
      s0_eol    <= in_valid && eol_w;
      s0_eof    <= in_valid && eof_w;
      s1_valid  <= s0_valid;
      s1_eol    <= s0_eol;
      s1_eof    <= s0_eof;
      s2_valid  <= s1_valid;
      s2_eol    <= s1_eol;
      s2_eof    <= s1_eof;
      out_valid <= s2_valid;
      out_pixel <= s2_valid ? pix_final : 8'd0;
      out_eol   <= s2_valid && s2_eol;
      out_eof   <= s2_valid && s2_eof;
    end
  end

  // Datapath registers carry no reset; their contents only matter when valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s0_ta <= t_a;  s0_tb <= t_b;  s0_tc <= t_c;
      s0_ma <= m_a;  s0_mc <= m_c;
      s0_ba <= b_a;  s0_bb <= b_b;  s0_bc <= b_c;
    end
    s1_gx  <= $signed(gx_pos - gx_neg);
    s1_gy  <= $signed(gy_pos - gy_neg);
    s2_mag <= abs_x + abs_y;
  end

  // Centre pixel has zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^m_b;
endmodule

// File: tb/tb_sobel_window_conv.sv
// Bench for sobel_window_conv: table vectors, hand sequences and random windows
// checked cycle-by-cycle against a kernel-level reference model.
module tb_sobel_window_conv;
  localparam int         IMG_W = 8;
  localparam int         IMG_H = 4;
  localparam logic [7:0] TH    = 8'd64;

  logic       clk = 1'b0;
  logic       rst, frame_start, in_valid;
  logic [7:0] t_a, t_b, t_c, m_a, m_b, m_c, b_a, b_b, b_c;
  logic       win_req, out_valid, out_eol, out_eof;
  logic [7:0] out_pixel;
  logic       sh_win_req, sh_valid, sh_eol, sh_eof;
  logic [7:0] sh_pixel;

  always #5 clk = ~clk;

  sobel_window_conv #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MAG_SHIFT(0), .THRESH(TH)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .t_a(t_a), .t_b(t_b), .t_c(t_c), .m_a(m_a), .m_b(m_b), .m_c(m_c),
    .b_a(b_a), .b_b(b_b), .b_c(b_c),
    .win_req(win_req), .out_valid(out_valid), .out_pixel(out_pixel),
    .out_eol(out_eol), .out_eof(out_eof));

  sobel_window_conv #(.IMG_W(IMG_W), .IMG_H(IMG_H), .MAG_SHIFT(2), .THRESH(TH)) u_dut_sh2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .t_a(t_a), .t_b(t_b), .t_c(t_c), .m_a(m_a), .m_b(m_b), .m_c(m_c),
    .b_a(b_a), .b_b(b_b), .b_c(b_c),
    .win_req(sh_win_req), .out_valid(sh_valid), .out_pixel(sh_pixel),
    .out_eol(sh_eol), .out_eof(sh_eof));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pos   = 0;
  logic [17:0] exp_q[$];
  int          due_q[$];
  logic        iv_edge  = 1'b0;
  logic        rst_edge = 1'b1;

  typedef struct {
    logic [8:0][7:0] w;
    logic [7:0]      e0;
    logic [7:0]      e2;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] thr(input logic [7:0] v);
`ifdef SOBEL_THRESH_EN
    return (v >= TH) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  // Reference: convolve with the Sobel kernels in plain integer arithmetic.
  function automatic logic [7:0] model(input logic [8:0][7:0] w, input int sh);
    int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int gx = 0;
    int gy = 0;
    int mag;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(w[i]);
      gy += ky[i] * int'(w[i]);
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    mag = mag >> sh;
    if (mag > 255) mag = 255;
    return thr(8'(mag));
  endfunction

  function automatic logic [8:0][7:0] win(input logic [7:0] ta, tb, tc, ma, mb, mc, ba, bb, bc);
    logic [8:0][7:0] w;
    w[0] = ta; w[1] = tb; w[2] = tc;
    w[3] = ma; w[4] = mb; w[5] = mc;
    w[6] = ba; w[7] = bb; w[8] = bc;
    return w;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    iv_edge  <= in_valid;
    rst_edge <= rst;
  end

  // Scoreboard: each expected output is due on a fixed cycle; otherwise idle zeros.
  always @(negedge clk) begin
    logic [17:0] e;
    if (cyc > 0) begin
      check("win_req", 32'(win_req), 32'(iv_edge && !rst_edge));
      check("win_req_sh2", 32'(sh_win_req), 32'(iv_edge && !rst_edge));
      if (due_q.size() > 0 && due_q[0] < cyc) begin
        check("missed_output", 32'(due_q[0]), 32'(cyc));
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_pixel", 32'(out_pixel), 32'(e[7:0]));
        check("out_eol", 32'(out_eol), 32'(e[16]));
        check("out_eof", 32'(out_eof), 32'(e[17]));
        check("sh2_valid", 32'(sh_valid), 32'd1);
        check("sh2_pixel", 32'(sh_pixel), 32'(e[15:8]));
        check("sh2_eol", 32'(sh_eol), 32'(e[16]));
        check("sh2_eof", 32'(sh_eof), 32'(e[17]));
      end else begin
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_pixel", 32'(out_pixel), 32'd0);
        check("idle_flags", 32'({out_eol, out_eof}), 32'd0);
        check("idle_sh2", 32'({sh_valid, sh_eol, sh_eof, sh_pixel}), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic fs, input logic [8:0][7:0] w,
                       input logic use_tbl, input logic [7:0] e0, input logic [7:0] e2);
    int col, row;
    logic eol, eof;
    logic [7:0] p0, p2;
    @(posedge clk); #1;
    rst = 1'b0; frame_start = fs; in_valid = v;
    {b_c, b_b, b_a, m_c, m_b, m_a, t_c, t_b, t_a} = w;
    if (fs) pos = 0;
    if (v) begin
      col = pos % IMG_W;
      row = (pos / IMG_W) % IMG_H;
      eol = (col == IMG_W - 1);
      eof = eol && (row == IMG_H - 1);
      p0  = use_tbl ? thr(e0) : model(w, 0);
      p2  = use_tbl ? thr(e2) : model(w, 2);
      exp_q.push_back({eof, eol, p2, p0});
      due_q.push_back(cyc + 4);
      pos = (pos + 1) % (IMG_W * IMG_H);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic send_rand(input logic fs);
    logic [8:0][7:0] w;
    for (int i = 0; i < 9; i++)
      w[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom_range(0, 255));
    drive(1'b1, fs, w, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    while (due_q.size() > 0 && due_q[due_q.size() - 1] >= cyc + 1) begin
      void'(due_q.pop_back());
      void'(exp_q.pop_back());
    end
    pos = 0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0;
    {t_a, t_b, t_c, m_a, m_b, m_c, b_a, b_b, b_c} = '0;

    tbl[0] = '{win(100, 100, 100, 100, 100, 100, 100, 100, 100), 8'd0,   8'd0};
    tbl[1] = '{win(0, 5, 10, 0, 5, 10, 0, 5, 10),                8'd40,  8'd10};
    tbl[2] = '{win(0, 0, 255, 0, 0, 255, 0, 0, 255),             8'd255, 8'd255};
    tbl[3] = '{win(50, 50, 50, 0, 0, 0, 0, 0, 0),                8'd200, 8'd50};
    tbl[4] = '{win(10, 10, 10, 0, 0, 0, 0, 0, 0),                8'd40,  8'd10};
    tbl[5] = '{win(0, 0, 0, 0, 0, 0, 0, 0, 200),                 8'd255, 8'd100};

    repeat (3) @(posedge clk);
    drive(1'b0, 1'b1, '0, 1'b0, 8'd0, 8'd0);

    // Isolated flat window first, then the remaining vectors back to back.
    drive(1'b1, 1'b0, tbl[0].w, 1'b1, tbl[0].e0, tbl[0].e2);
    idle(5);
    for (int i = 1; i < 6; i++) drive(1'b1, 1'b0, tbl[i].w, 1'b1, tbl[i].e0, tbl[i].e2);
    idle(4);

    // Move to column 3 of row 1, then frame_start together with a window.
    repeat (5) send_rand(1'b0);
    send_rand(1'b1);
    repeat (9) send_rand(1'b0);
    idle(2);

    // Several frames of random windows with gaps and occasional frame_start.
    for (int i = 0; i < 140; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_rand($urandom_range(0, 49) == 0);
    end

    // Reset with three windows in flight; first window after is col 0.
    repeat (3) send_rand(1'b0);
    do_reset();
    idle(3);
    repeat (IMG_W + 2) send_rand(1'b0);

    idle(8);
    check("drain_empty", 32'(due_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sobel_window_conv.md
Name: sobel_window_conv

Overview:
Downstream consumer of the three row line-buffers. Each cycle it takes one 3x3 window of 8-bit grey pixels: three adjacent pixels from each of the top, middle and bottom rows. It computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline, then emits one 8-bit edge pixel per accepted window. It also tracks column and row position so it can flag end-of-line and end-of-frame for the downstream frame writer.

Parameters:
IMG_W, 640, windows per line; the column counter wraps at IMG_W-1.
IMG_H, 480, lines per frame; the row counter wraps at IMG_H-1.
MAG_SHIFT, 0, right shift applied to the 11-bit magnitude before saturation (0..3).
THRESH, 8'd64, binarisation threshold; used only when SOBEL_THRESH_EN is defined.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
frame_start  input  1  1-cycle pulse; clears the col/row counters.
in_valid  input  1  window on the inputs is valid this cycle.
t_a, t_b, t_c  input  8 each  top row pixels, left/centre/right.
m_a, m_b, m_c  input  8 each  middle row pixels, left/centre/right.
b_a, b_b, b_c  input  8 each  bottom row pixels, left/centre/right.
win_req  output  1  rd_en to the row buffers; advance one column.
out_valid  output  1  out_pixel is valid.
out_pixel  output  8  edge magnitude (or 0/255 when binarised).
out_eol  output  1  qualifies out_valid; last column of a line.
out_eof  output  1  qualifies out_valid; last pixel of the frame.

Behaviour:
- Reset (rst=1 at a posedge):
  - out_valid, out_pixel, out_eol, out_eof and win_req go to 0 the next cycle.
  - All pipeline valid bits are cleared; col_cnt=0, row_cnt=0.
  - rst has priority over frame_start and in_valid.
  - Reset mid-pipeline discards in-flight windows; no partial output is produced.
- win_req = registered in_valid (1-cycle delay), 0 during reset. The row buffers advance exactly once per accepted window.
- Stage 0 (accept): when in_valid=1, register the 9 pixels, the valid bit, and eol = (col_cnt==IMG_W-1), eof = eol && (row_cnt==IMG_H-1).
- Counters:
  - col_cnt increments on each accepted window and wraps to 0 after IMG_W-1; on wrap row_cnt increments.
  - row_cnt wraps to 0 after IMG_H-1.
  - frame_start=1 forces col_cnt=row_cnt=0 first. If in_valid is also high that cycle, that window is treated as col 0, row 0, and the counters become col 1, row 0.
- Stage 1: Gx and Gy as 11-bit signed, operands zero-extended before arithmetic.
  - Gx = (t_c + 2*m_c + b_c) - (t_a + 2*m_a + b_a).
  - Gy = (b_a + 2*b_b + b_c) - (t_a + 2*t_b + t_c).
  - Range for each is -1020..+1020.
- Stage 2: mag = |Gx| + |Gy|, 11-bit unsigned, range 0..2040.
- Stage 3: s = mag >> MAG_SHIFT, then out_pixel = (s > 255) ? 255 : s[7:0]. Output registers are loaded.
- Latency: a window accepted at cycle N (in_valid high at posedge N) appears with out_valid=1 at posedge N+3.
- Throughput: 1 window/cycle, no stall; in_valid gaps propagate as out_valid gaps.
- eol/eof flags travel with their data through all stages.
- When out_valid=0, out_pixel, out_eol and out_eof hold 0.
- No border handling here; zero padding is supplied by the row buffers.

Optional Feature:
SOBEL_THRESH_EN.
- Defined: stage 3 additionally compares the saturated value s_sat against THRESH. out_pixel = 8'd255 if s_sat >= THRESH, else 8'd0. Latency is unchanged (3 cycles).
- Undefined: out_pixel is the saturated magnitude and the THRESH parameter is unused.

Test Plan:
- Flat window: all nine pixels = 100, in_valid one cycle -> out_valid 3 cycles later, out_pixel=0, out_eol=0; win_req high 1 cycle after in_valid.
- Vertical edge: left column 0, right column 10, centre 5 -> Gx=40, Gy=0 -> out_pixel=40. Left 0 / right 255 -> Gx=1020 -> out_pixel=255 (saturation); with MAG_SHIFT=2 -> 255 (1020>>2=255).
- Horizontal edge: top row 50, middle and bottom 0 -> Gy=-200, Gx=0 -> out_pixel=200. With SOBEL_THRESH_EN and THRESH=64 -> 255; top row 10 -> Gy=-40 -> 0.
- Line/frame counting: frame_start pulse, then IMG_W*IMG_H consecutive valid windows -> out_eol on outputs 640, 1280, ...; out_eof only on output 307200; counters back at 0; gaps in in_valid do not change the counts.
- frame_start together with in_valid mid-line (col_cnt=300) -> that window is col 0 of row 0; out_eol on the 640th output counted from it.
- Reset mid-stream: 3 windows in flight, rst=1 one cycle -> out_valid=0 from the next cycle, no stale outputs after release; first window afterwards is col 0.
